// File: rtl/upperimm_decode_queue.sv
// Decodes U-type (LUI/AUIPC) instructions and queues rd/imm/alu/pc/result in a DEPTH-entry FIFO.
// Latency: one cycle from accept to head output when the queue is empty; one instruction per cycle sustained.
// Backpressure: in_ready drops while full (no pass-through on a same-cycle pop); head is held while out_ready is low.
module upperimm_decode_queue #(
    parameter int         XLEN      = 32,
    parameter int         DEPTH     = 2,
    parameter logic [4:0] ALU_LUI   = 5'd10,
    parameter logic [4:0] ALU_AUIPC = 5'd11,
    parameter logic [4:0] ALU_NOP   = 5'd0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction_code,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_alu_control,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_result,
    output logic            out_illegal,
    output logic [7:0]      illegal_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [6:0]    OPC_LUI   = 7'b0110111;
    localparam logic [6:0]    OPC_AUIPC = 7'b0010111;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [4:0]      alu;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] result;
        logic            illegal;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      illegal_count_q, illegal_count_d;

    entry_t          dec;
    entry_t          head;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext;
    logic            push;
    logic            pop;

    assign in_ready      = (count_q < DEPTH_C);
    assign out_valid     = (count_q != '0);
    assign push          = in_valid && in_ready;
    assign pop           = out_valid && out_ready;
    assign illegal_count = illegal_count_q;

    // Decode the incoming instruction into a queue entry; non-U-type opcodes become zeroed illegal entries.
    always_comb begin
        imm32   = {instruction_code[31:12], 12'h000};
        imm_ext = XLEN'($signed(imm32));
        dec     = '0;
        dec.pc  = pc;
        case (instruction_code[6:0])
            OPC_LUI: begin
                dec.rd     = instruction_code[11:7];
                dec.imm    = imm_ext;
                dec.alu    = ALU_LUI;
                dec.result = imm_ext;
            end
            OPC_AUIPC: begin
                dec.rd     = instruction_code[11:7];
                dec.imm    = imm_ext;
                dec.alu    = ALU_AUIPC;
                dec.result = pc + imm_ext;
            end
            default: begin
                dec.alu     = ALU_NOP;
                dec.illegal = 1'b1;
            end
        endcase
    end

    // Next-state for pointers, occupancy, storage and the illegal counter; flush wins over push/pop.
    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        illegal_count_d = illegal_count_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = dec;
                wr_ptr_d        = wr_ptr_q + 1'b1;
                if (dec.illegal && (illegal_count_q != 8'hFF)) begin
                    illegal_count_d = illegal_count_q + 8'd1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset empties the queue and clears storage so outputs never go unknown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            illegal_count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            illegal_count_q <= illegal_count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Present the head entry; forced to zero while empty so reset drops the outputs without a clock edge.
    always_comb begin
        head = mem_q[rd_ptr_q];
        if (!out_valid) begin
            head = '0;
        end
        out_rd          = head.rd;
        out_imm         = head.imm;
        out_alu_control = head.alu;
        out_pc          = head.pc;
        out_result      = head.result;
        out_illegal     = head.illegal;
    end

endmodule

// File: tb/tb_upperimm_decode_queue.sv
module tb_upperimm_decode_queue;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [63:0] pc64;

    logic        r32_in_ready, r32_out_valid, r32_out_illegal;
    logic [4:0]  r32_out_rd, r32_out_alu;
    logic [31:0] r32_out_imm, r32_out_pc, r32_out_result;
    logic [7:0]  r32_illegal_count;

    logic        r64_in_ready, r64_out_valid, r64_out_illegal;
    logic [4:0]  r64_out_rd, r64_out_alu;
    logic [63:0] r64_out_imm, r64_out_pc, r64_out_result;
    logic [7:0]  r64_illegal_count;

    upperimm_decode_queue #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(r32_in_ready),
        .instruction_code(in_instr), .pc(pc64[31:0]),
        .out_valid(r32_out_valid), .out_ready(out_ready),
        .out_rd(r32_out_rd), .out_imm(r32_out_imm),
        .out_alu_control(r32_out_alu), .out_pc(r32_out_pc),
        .out_result(r32_out_result), .out_illegal(r32_out_illegal),
        .illegal_count(r32_illegal_count)
    );

    upperimm_decode_queue #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(r64_in_ready),
        .instruction_code(in_instr), .pc(pc64),
        .out_valid(r64_out_valid), .out_ready(out_ready),
        .out_rd(r64_out_rd), .out_imm(r64_out_imm),
        .out_alu_control(r64_out_alu), .out_pc(r64_out_pc),
        .out_result(r64_out_result), .out_illegal(r64_out_illegal),
        .illegal_count(r64_illegal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] pc;
    } txn_t;

    txn_t mq[$];
    int   m_ill;
    int   n_cmp;
    int   n_fail;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit is_lui(input logic [31:0] ins);
        return ins[6:0] == 7'h37;
    endfunction

    function automatic bit is_auipc(input logic [31:0] ins);
        return ins[6:0] == 7'h17;
    endfunction

    function automatic bit m_illegal(input logic [31:0] ins);
        return !(is_lui(ins) || is_auipc(ins));
    endfunction

    // Upper 20 bits shifted left by 12, sign-extended to 64 bits.
    function automatic logic [63:0] m_imm(input logic [31:0] ins);
        logic [63:0] v;
        if (m_illegal(ins)) return 64'd0;
        v = {{32{ins[31]}}, ins[31:12], 12'h000};
        return v;
    endfunction

    function automatic logic [63:0] m_res(input logic [31:0] ins, input logic [63:0] p);
        if (is_lui(ins)) return m_imm(ins);
        if (is_auipc(ins)) return p + m_imm(ins);
        return 64'd0;
    endfunction

    function automatic logic [4:0] m_rd(input logic [31:0] ins);
        return m_illegal(ins) ? 5'd0 : ins[11:7];
    endfunction

    function automatic logic [4:0] m_alu(input logic [31:0] ins);
        if (is_lui(ins)) return 5'd10;
        if (is_auipc(ins)) return 5'd11;
        return 5'd0;
    endfunction

    task automatic check_all();
        txn_t t;
        chk("in_ready32", 64'(r32_in_ready), 64'(mq.size() < DEPTH));
        chk("in_ready64", 64'(r64_in_ready), 64'(mq.size() < DEPTH));
        chk("out_valid32", 64'(r32_out_valid), 64'(mq.size() != 0));
        chk("out_valid64", 64'(r64_out_valid), 64'(mq.size() != 0));
        chk("ill_cnt32", 64'(r32_illegal_count), 64'(m_ill));
        chk("ill_cnt64", 64'(r64_illegal_count), 64'(m_ill));
        if (mq.size() != 0) begin
            t = mq[0];
            chk("rd32", 64'(r32_out_rd), 64'(m_rd(t.ins)));
            chk("imm32", 64'(r32_out_imm), {32'd0, m_imm(t.ins) & 64'hFFFF_FFFF});
            chk("alu32", 64'(r32_out_alu), 64'(m_alu(t.ins)));
            chk("pc32", 64'(r32_out_pc), t.pc & 64'hFFFF_FFFF);
            chk("res32", 64'(r32_out_result), m_res(t.ins, t.pc) & 64'hFFFF_FFFF);
            chk("ill32", 64'(r32_out_illegal), 64'(m_illegal(t.ins)));
            chk("rd64", 64'(r64_out_rd), 64'(m_rd(t.ins)));
            chk("imm64", r64_out_imm, m_imm(t.ins));
            chk("alu64", 64'(r64_out_alu), 64'(m_alu(t.ins)));
            chk("pc64", r64_out_pc, t.pc);
            chk("res64", r64_out_result, m_res(t.ins, t.pc));
            chk("ill64", 64'(r64_out_illegal), 64'(m_illegal(t.ins)));
        end
    endtask

    // Drive one cycle from a negedge, advance the model, then compare at the next negedge.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [63:0] p,
                         input logic ordy, input logic fl);
        bit acc;
        bit pp;
        txn_t t;
        in_valid  = v;
        in_instr  = ins;
        pc64      = p;
        out_ready = ordy;
        flush     = fl;
        acc = v && (mq.size() < DEPTH);
        pp  = (mq.size() != 0) && ordy;
        if (fl) begin
            mq.delete();
        end else begin
            if (pp) void'(mq.pop_front());
            if (acc) begin
                t.ins = ins;
                t.pc  = p;
                mq.push_back(t);
                if (m_illegal(ins) && m_ill < 255) m_ill++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int sel;
        ins = $urandom;
        sel = $urandom_range(0, 2);
        if (sel == 0) ins[6:0] = 7'h37;
        else if (sel == 1) ins[6:0] = 7'h17;
        return ins;
    endfunction

    initial begin
        n_cmp = 0;
        n_fail = 0;
        m_ill = 0;
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h123452B7;
        pc64 = 64'h100;
        out_ready = 1'b0;

        // Reset: pushes ignored, outputs zero, ready high.
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(r32_out_valid), 64'd0);
        chk("rst_in_ready", 64'(r32_in_ready), 64'd1);
        chk("rst_result", 64'(r32_out_result), 64'd0);
        chk("rst_imm64", r64_out_imm, 64'd0);
        chk("rst_ill_cnt", 64'(r64_illegal_count), 64'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        check_all();

        // LUI x5, 0x12345
        cycle(1'b1, 32'h123452B7, 64'h100, 1'b0, 1'b0);
        chk("lui_valid", 64'(r32_out_valid), 64'd1);
        chk("lui_rd", 64'(r32_out_rd), 64'd5);
        chk("lui_imm", 64'(r32_out_imm), 64'h12345000);
        chk("lui_res", 64'(r32_out_result), 64'h12345000);
        chk("lui_alu", 64'(r32_out_alu), 64'd10);

        // AUIPC x1, 0xFFFFF at pc 0x1000 wraps to zero
        cycle(1'b1, 32'hFFFFF097, 64'h1000, 1'b1, 1'b0);
        chk("auipc_imm32", 64'(r32_out_imm), 64'hFFFFF000);
        chk("auipc_res32", 64'(r32_out_result), 64'h0);
        chk("auipc_imm64", r64_out_imm, 64'hFFFFFFFFFFFFF000);
        chk("auipc_res64", r64_out_result, 64'h0);
        chk("auipc_rd", 64'(r64_out_rd), 64'd1);

        // ADDI is illegal
        cycle(1'b1, 32'h00100093, 64'h200, 1'b1, 1'b0);
        chk("addi_ill", 64'(r32_out_illegal), 64'd1);
        chk("addi_alu", 64'(r32_out_alu), 64'd0);
        chk("addi_rd", 64'(r32_out_rd), 64'd0);
        chk("addi_res", 64'(r32_out_result), 64'd0);
        chk("addi_pc", 64'(r32_out_pc), 64'h200);
        chk("addi_cnt", 64'(r32_illegal_count), 64'd1);
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Backpressure with three pushes into a two-entry queue
        cycle(1'b1, 32'h0000A037, 64'hA00, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000B037, 64'hB00, 1'b0, 1'b0);
        chk("bp_full_ready", 64'(r32_in_ready), 64'd0);
        cycle(1'b1, 32'h0000C037, 64'hC00, 1'b0, 1'b0);
        chk("bp_held_pc", 64'(r32_out_pc), 64'hA00);
        cycle(1'b1, 32'h0000C037, 64'hC00, 1'b1, 1'b0);
        chk("bp_order_b", 64'(r32_out_pc), 64'hB00);
        chk("bp_ready_back", 64'(r32_in_ready), 64'd1);
        cycle(1'b1, 32'h0000C037, 64'hC00, 1'b1, 1'b0);
        chk("bp_order_c", 64'(r64_out_pc), 64'hC00);
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk("bp_drained", 64'(r32_out_valid), 64'd0);

        // Flush on a full queue with simultaneous illegal push and pop
        cycle(1'b1, 32'h00001037, 64'h10, 1'b0, 1'b0);
        cycle(1'b1, 32'h00002017, 64'h20, 1'b0, 1'b0);
        cycle(1'b1, 32'h00100093, 64'h30, 1'b1, 1'b1);
        chk("fl_valid", 64'(r32_out_valid), 64'd0);
        chk("fl_ready", 64'(r64_in_ready), 64'd1);
        chk("fl_ill_cnt", 64'(r32_illegal_count), 64'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), rand_instr(), {$urandom, $urandom},
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0));
        end
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // 300 illegal instructions saturate the counter
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, 32'h00000013, 64'(i), 1'b1, 1'b0);
        end
        chk("sat_cnt32", 64'(r32_illegal_count), 64'd255);
        chk("sat_cnt64", 64'(r64_illegal_count), 64'd255);
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Asynchronous reset with two entries queued
        cycle(1'b1, 32'h123452B7, 64'h40, 1'b0, 1'b0);
        cycle(1'b1, 32'hFFFFF097, 64'h50, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid32", 64'(r32_out_valid), 64'd0);
        chk("arst_valid64", 64'(r64_out_valid), 64'd0);
        chk("arst_res64", r64_out_result, 64'd0);
        chk("arst_ready", 64'(r32_in_ready), 64'd1);
        chk("arst_cnt", 64'(r32_illegal_count), 64'd0);
        mq.delete();
        m_ill = 0;
        @(negedge clk);
        rst = 1'b0;
        check_all();
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk("post_rst_valid", 64'(r32_out_valid), 64'd0);
        chk("post_rst_cnt", 64'(r64_illegal_count), 64'd0);
        cycle(1'b1, 32'h00003017, 64'h60, 1'b1, 1'b0);
        chk("post_rst_res", 64'(r32_out_result), 64'h3060);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/upperimm_decode_queue.md
# upperimm_decode_queue

Registered, parametrised decode stage for RISC-V U-type instructions (LUI, AUIPC) with valid/ready handshakes on both sides and a DEPTH-entry result queue. It sits between fetch and execute. It decodes rd, immediate and ALU control, and precomputes the U-type result (imm for LUI, pc+imm for AUIPC). It also flags non-U-type opcodes as illegal and keeps a saturating count of them.

## Interface
Parameters:
- XLEN, 32 — datapath width; legal values 32 or 64.
- DEPTH, 2 — result queue entries; power of two, ≥2.
- ALU_LUI, 5'd10 — alu_control code emitted for LUI.
- ALU_AUIPC, 5'd11 — alu_control code emitted for AUIPC.
- ALU_NOP, 5'd0 — alu_control code emitted for illegal entries.

Ports:
- clk  in  1  — clock, rising edge.
- rst  in  1  — asynchronous, active-high reset.
- flush  in  1  — synchronous queue clear.
- in_valid  in  1  — instruction presented.
- in_ready  out  1  — queue can accept.
- instruction_code  in  32  — raw instruction.
- pc  in  XLEN  — instruction address.
- out_valid  out  1  — head entry valid.
- out_ready  in  1  — consumer takes head.
- out_rd  out  5  — destination register.
- out_imm  out  XLEN  — {instr[31:12],12'b0}, sign-extended to XLEN.
- out_alu_control  out  5  — ALU_LUI, ALU_AUIPC or ALU_NOP.
- out_pc  out  XLEN  — pc of the entry.
- out_result  out  XLEN  — LUI: imm; AUIPC: pc+imm mod 2^XLEN; illegal: 0.
- out_illegal  out  1  — opcode is neither 0110111 nor 0010111.
- illegal_count  out  8  — saturating count of illegal instructions accepted.

## Operation
- Push: in_valid && in_ready. Decode is computed combinationally from instruction_code and pc, then written to the tail entry.
- Opcode instr[6:0]:
  - 0110111: LUI.
  - 0010111: AUIPC.
  - Anything else: illegal entry with rd=0, imm=0, result=0, alu_control=ALU_NOP, out_illegal=1. pc is still stored.
- rd = instr[11:7] for legal entries. The immediate's bit 31 is replicated into bits XLEN-1:32 when XLEN=64.
- Pop: out_valid && out_ready. The head advances.
- in_ready = (count < DEPTH). There is no same-cycle pass-through when full, even if a pop occurs that cycle.
- out_valid = (count != 0). The out_* fields show the head entry and are held stable while out_valid && !out_ready.
- count tracks occupancy:
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
- illegal_count increments on each accepted illegal push and saturates at 255. It is cleared only by rst; flush does not clear it.
- flush: count, read and write pointers go to 0 on the next edge. flush has priority over a push or pop in the same cycle; those are discarded and do not affect illegal_count.

## Timing
- Reset (async assert, released synchronously to clk by the system):
  - count, pointers, illegal_count = 0.
  - out_valid = 0, all out_* data outputs = 0.
  - in_ready = 1 while in reset; pushes during reset are ignored.
- Latency: an instruction accepted at edge N appears at the outputs with out_valid=1 after edge N (visible in cycle N+1) if the queue was empty.
- Throughput: one instruction per cycle, sustained, when out_ready=1.
- Full (count=DEPTH): in_ready=0. It returns to 1 the cycle after a pop.
- Empty: out_valid=0. The out_* data outputs are don't-care but must not produce X after reset.
- Reset mid-operation: all queued entries are lost immediately, and the outputs take their reset values asynchronously.

## Test plan
- LUI x5,0x12345 (0x123452B7), pc=0x100, XLEN=32 → out_rd=5, out_imm=0x12345000, out_result=0x12345000, alu=ALU_LUI, out_valid one cycle after accept.
- AUIPC x1,0xFFFFF (0xFFFFF097), pc=0x1000:
  - XLEN=32 → imm=0xFFFFF000, result=0x00000000 (wrap).
  - XLEN=64 → imm=0xFFFFFFFFFFFFF000, result=0x0.
- Backpressure: out_ready=0, push 3 instructions with DEPTH=2 → in_ready=0 after 2 pushes, third held. Raise out_ready → order preserved; in_ready returns 1 next cycle.
- Illegal: push ADDI (0x00100093) → out_illegal=1, alu=ALU_NOP, rd=0, result=0, illegal_count=1. Push 300 illegal instructions → illegal_count=255.
- Flush with a simultaneous push and pop on a full queue → next cycle count=0, out_valid=0, in_ready=1, illegal_count unchanged.
- Assert rst while 2 entries are queued → out_valid drops to 0 without waiting for a clock edge; after release the queue is empty and illegal_count=0.
